// File: rtl/dispatch_unit.sv
// -----------------------------------------------------------------------------
// dispatch_unit
//
// Producer side of the reservation-station dispatch interface. Takes one
// decoded instruction per cycle, renames its sources against a register-status
// table, allocates a 3-bit result tag and drives a registered packet into the
// RS. ALU/memory broadcast buses and the commit port are snooped so operands
// already produced travel as values rather than tags.
//
// Optional build macro:
//   DISPATCH_PERF_CNT_EN - enables the stall_rs_cnt / stall_tag_cnt counters.
//                          When undefined both ports are tied to zero.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   inst_*              decoded instruction in, inst_ready handshake out
//   rs_full             RS back-pressure
//   alu_*/memory_*      result broadcast buses (tag 0 = idle)
//   commit_valid/tag    retire one tag per cycle
//   flush               squash all in-flight state (regfile kept)
//   op..is_branch       registered dispatch packet to the RS
//   stall_*_cnt         performance counters
// -----------------------------------------------------------------------------
module dispatch_unit #(
  parameter int         NUM_TAGS = 7,
  parameter logic [4:0] NOP_OP   = 5'b11111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [4:0]  inst_op,
  input  logic [4:0]  inst_rd,
  input  logic [4:0]  inst_rs1,
  input  logic [4:0]  inst_rs2,
  input  logic        inst_uses_rs2,
  input  logic        inst_writes_rd,
  input  logic [31:0] inst_imm,
  input  logic        inst_is_branch,
  input  logic        rs_full,
  input  logic [2:0]  alu_des_in,
  input  logic [2:0]  memory_des_in,
  input  logic [31:0] alu_data,
  input  logic [31:0] memory_data,
  input  logic        commit_valid,
  input  logic [2:0]  commit_tag,
  input  logic        flush,
  output logic [4:0]  op,
  output logic [31:0] value1,
  output logic [31:0] value2,
  output logic [31:0] imm,
  output logic [2:0]  query1,
  output logic [2:0]  query2,
  output logic [2:0]  des,
  output logic        is_branch,
  output logic [31:0] stall_rs_cnt,
  output logic [31:0] stall_tag_cnt
);

  localparam int TW = 3;
  localparam int NT = 1 << TW;

  typedef struct packed {
    logic [TW-1:0] q;
    logic [31:0]   v;
  } opnd_t;

  // Tag table (index 0 is never allocated)
  logic [NT-1:0] busy_q, busy_d;
  logic [NT-1:0] wr_q, wr_d;
  logic [NT-1:0] rv_q, rv_d;
  logic [4:0]    trd_q [NT];
  logic [4:0]    trd_d [NT];
  logic [31:0]   res_q [NT];
  logic [31:0]   res_d [NT];

  // Register status and architectural register file
  logic [TW-1:0] reg_tag_q [32];
  logic [TW-1:0] reg_tag_d [32];
  logic [31:0]   rf_q [32];
  logic [31:0]   rf_d [32];

  // Output packet registers
  logic [4:0]    op_q, op_d;
  logic [31:0]   value1_q, value1_d, value2_q, value2_d, imm_q, imm_d;
  logic [TW-1:0] query1_q, query1_d, query2_q, query2_d, des_q, des_d;
  logic          br_q, br_d;

  logic [TW-1:0] free_tag;
  logic          tag_avail;
  logic          accept;
  logic          commit_hit;
  logic [TW-1:0] src1_tag, src2_tag;
  opnd_t         opnd1, opnd2;

  // Lowest-numbered free tag; only the registered busy state is consulted so a
  // tag freed by commit becomes allocatable one cycle later.
  always_comb begin
    free_tag  = '0;
    tag_avail = 1'b0;
    for (int i = NUM_TAGS; i >= 1; i--) begin
      if (!busy_q[i]) begin
        free_tag  = TW'(i);
        tag_avail = 1'b1;
      end
    end
  end

  assign inst_ready = rst & ~rs_full & ~flush & tag_avail;
  assign accept     = inst_valid & inst_ready;
  assign commit_hit = commit_valid & (commit_tag != '0) & busy_q[commit_tag];

  function automatic opnd_t resolve(input logic [4:0]    rs,
                                    input logic [TW-1:0] tag,
                                    input logic [31:0]   rf_val,
                                    input logic          rv,
                                    input logic [31:0]   stored);
    opnd_t r;
    r = '0;
    if (rs == 5'd0) begin
      r = '0;
    end else if (tag == '0) begin
      r.v = rf_val;
    end else if (rv) begin
      r.v = stored;
    end else if ((alu_des_in != '0) && (alu_des_in == tag)) begin
      r.v = alu_data;
    end else if ((memory_des_in != '0) && (memory_des_in == tag)) begin
      r.v = memory_data;
    end else if (commit_valid && (commit_tag == tag)) begin
      r.v = stored;
    end else begin
      r.q = tag;
    end
    return r;
  endfunction

  assign src1_tag = reg_tag_q[inst_rs1];
  assign src2_tag = reg_tag_q[inst_rs2];
  assign opnd1 = resolve(inst_rs1, src1_tag, rf_q[inst_rs1], rv_q[src1_tag], res_q[src1_tag]);
  assign opnd2 = resolve(inst_rs2, src2_tag, rf_q[inst_rs2], rv_q[src2_tag], res_q[src2_tag]);

  // Table next-state. Order matters: broadcast capture, then commit, then the
  // new allocation (so a same-cycle dispatch to the committed rd keeps its
  // rename), and flush overrides all of it.
  always_comb begin
    busy_d    = busy_q;
    wr_d      = wr_q;
    rv_d      = rv_q;
    trd_d     = trd_q;
    res_d     = res_q;
    reg_tag_d = reg_tag_q;
    rf_d      = rf_q;

    if ((alu_des_in != '0) && busy_q[alu_des_in]) begin
      rv_d[alu_des_in]  = 1'b1;
      res_d[alu_des_in] = alu_data;
    end
    if ((memory_des_in != '0) && busy_q[memory_des_in]) begin
      rv_d[memory_des_in]  = 1'b1;
      res_d[memory_des_in] = memory_data;
    end

    if (commit_hit) begin
      if (wr_q[commit_tag] && (trd_q[commit_tag] != 5'd0)) begin
        rf_d[trd_q[commit_tag]] = res_q[commit_tag];
        if (reg_tag_q[trd_q[commit_tag]] == commit_tag) begin
          reg_tag_d[trd_q[commit_tag]] = '0;
        end
      end
      busy_d[commit_tag] = 1'b0;
      rv_d[commit_tag]   = 1'b0;
    end

    if (accept) begin
      busy_d[free_tag] = 1'b1;
      wr_d[free_tag]   = inst_writes_rd;
      trd_d[free_tag]  = inst_rd;
      rv_d[free_tag]   = 1'b0;
      if (inst_writes_rd && (inst_rd != 5'd0)) begin
        reg_tag_d[inst_rd] = free_tag;
      end
    end

    if (flush) begin
      busy_d = '0;
      rv_d   = '0;
      rf_d   = rf_q;
      for (int i = 0; i < 32; i++) begin
        reg_tag_d[i] = '0;
      end
    end
  end

  // Packet next-state; imm follows inst_imm every cycle.
  always_comb begin
    op_d     = NOP_OP;
    value1_d = '0;
    value2_d = '0;
    query1_d = '0;
    query2_d = '0;
    des_d    = '0;
    br_d     = 1'b0;
    imm_d    = inst_imm;
    if (accept) begin
      op_d     = inst_op;
      des_d    = free_tag;
      br_d     = inst_is_branch;
      value1_d = opnd1.v;
      query1_d = opnd1.q;
      if (inst_uses_rs2) begin
        value2_d = opnd2.v;
        query2_d = opnd2.q;
      end else begin
        value2_d = inst_imm;
        query2_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q   <= '0;
      wr_q     <= '0;
      rv_q     <= '0;
      for (int i = 0; i < NT; i++) begin
        trd_q[i] <= '0;
        res_q[i] <= '0;
      end
      for (int i = 0; i < 32; i++) begin
        reg_tag_q[i] <= '0;
        rf_q[i]      <= '0;
      end
      op_q     <= NOP_OP;
      value1_q <= '0;
      value2_q <= '0;
      imm_q    <= '0;
      query1_q <= '0;
      query2_q <= '0;
      des_q    <= '0;
      br_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      wr_q      <= wr_d;
      rv_q      <= rv_d;
      trd_q     <= trd_d;
      res_q     <= res_d;
      reg_tag_q <= reg_tag_d;
      rf_q      <= rf_d;
      op_q      <= op_d;
      value1_q  <= value1_d;
      value2_q  <= value2_d;
      imm_q     <= imm_d;
      query1_q  <= query1_d;
      query2_q  <= query2_d;
      des_q     <= des_d;
      br_q      <= br_d;
    end
  end

  assign op        = op_q;
  assign value1    = value1_q;
  assign value2    = value2_q;
  assign imm       = imm_q;
  assign query1    = query1_q;
  assign query2    = query2_q;
  assign des       = des_q;
  assign is_branch = br_q;

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_rs_q, stall_tag_q;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      stall_rs_q  <= '0;
      stall_tag_q <= '0;
    end else begin
      if (inst_valid && rs_full && (stall_rs_q != 32'hFFFF_FFFF)) begin
        stall_rs_q <= stall_rs_q + 32'd1;
      end
      if (inst_valid && !rs_full && !tag_avail && (stall_tag_q != 32'hFFFF_FFFF)) begin
        stall_tag_q <= stall_tag_q + 32'd1;
      end
    end
  end

  assign stall_rs_cnt  = stall_rs_q;
  assign stall_tag_cnt = stall_tag_q;
`else
  assign stall_rs_cnt  = '0;
  assign stall_tag_cnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
module tb_dispatch_unit;

  localparam logic [4:0] NOP = 5'b11111;
  localparam logic [4:0] ADD = 5'd0;
  localparam logic [4:0] SW  = 5'd20;
  localparam logic [4:0] BEQ = 5'd24;

`ifdef DISPATCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, inst_ready;
  logic [4:0]  inst_op, inst_rd, inst_rs1, inst_rs2;
  logic        inst_uses_rs2, inst_writes_rd, inst_is_branch;
  logic [31:0] inst_imm;
  logic        rs_full;
  logic [2:0]  alu_des_in, memory_des_in;
  logic [31:0] alu_data, memory_data;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic        flush;
  logic [4:0]  op;
  logic [31:0] value1, value2, imm;
  logic [2:0]  query1, query2, des;
  logic        is_branch;
  logic [31:0] stall_rs_cnt, stall_tag_cnt;

  dispatch_unit dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_op(inst_op), .inst_rd(inst_rd), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
    .inst_uses_rs2(inst_uses_rs2), .inst_writes_rd(inst_writes_rd),
    .inst_imm(inst_imm), .inst_is_branch(inst_is_branch),
    .rs_full(rs_full),
    .alu_des_in(alu_des_in), .memory_des_in(memory_des_in),
    .alu_data(alu_data), .memory_data(memory_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .flush(flush),
    .op(op), .value1(value1), .value2(value2), .imm(imm),
    .query1(query1), .query2(query2), .des(des), .is_branch(is_branch),
    .stall_rs_cnt(stall_rs_cnt), .stall_tag_cnt(stall_tag_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [2:0]  q1;
    logic [2:0]  q2;
    logic [2:0]  des;
    logic [31:0] imm;
    logic        br;
  } pkt_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  op, rd, rs1, rs2;
    logic        u2, wr, br, full, cv, fl;
    logic [31:0] im;
    logic [2:0]  ad, md, ct;
    logic [31:0] adat, mdat;
    logic        e_rdy;
    pkt_t        e;
  } vec_t;

  int   ntests = 0;
  int   nfail  = 0;
  pkt_t exp_q[$];
  vec_t vt[$];

  function automatic pkt_t pk(logic [4:0] o, logic [31:0] a, logic [31:0] b,
                              logic [2:0] qa, logic [2:0] qb, logic [2:0] d,
                              logic [31:0] im, logic br);
    pkt_t p;
    p.op = o; p.v1 = a; p.v2 = b; p.q1 = qa; p.q2 = qb;
    p.des = d; p.imm = im; p.br = br;
    return p;
  endfunction

  function automatic vec_t mk(string n, logic [4:0] o, logic [4:0] rd,
                              logic [4:0] r1, logic [4:0] r2, logic u2,
                              logic wr, logic [31:0] im, logic br);
    vec_t v;
    v.name = n; v.valid = 1'b1; v.op = o; v.rd = rd; v.rs1 = r1; v.rs2 = r2;
    v.u2 = u2; v.wr = wr; v.im = im; v.br = br;
    v.full = 1'b0; v.cv = 1'b0; v.fl = 1'b0; v.ct = '0;
    v.ad = '0; v.adat = '0; v.md = '0; v.mdat = '0;
    v.e_rdy = 1'b0;
    v.e = pk(NOP, 0, 0, 0, 0, 0, im, 1'b0);
    return v;
  endfunction

  task automatic run_one(input vec_t v);
    pkt_t got, e;
    inst_valid = v.valid; inst_op = v.op; inst_rd = v.rd;
    inst_rs1 = v.rs1; inst_rs2 = v.rs2; inst_uses_rs2 = v.u2;
    inst_writes_rd = v.wr; inst_imm = v.im; inst_is_branch = v.br;
    rs_full = v.full; alu_des_in = v.ad; alu_data = v.adat;
    memory_des_in = v.md; memory_data = v.mdat;
    commit_valid = v.cv; commit_tag = v.ct; flush = v.fl;
    #1;
    ntests++;
    if (inst_ready !== v.e_rdy) begin
      nfail++;
      $display("FAIL %s ready: got %0b expected %0b", v.name, inst_ready, v.e_rdy);
    end
    exp_q.push_back(v.e);
    @(posedge clk);
    #1;
    got = pk(op, value1, value2, query1, query2, des, imm, is_branch);
    e = exp_q.pop_front();
    ntests++;
    if (got !== e) begin
      nfail++;
      $display("FAIL %s packet: got op=%h v1=%h v2=%h q1=%0d q2=%0d des=%0d imm=%h br=%0b expected op=%h v1=%h v2=%h q1=%0d q2=%0d des=%0d imm=%h br=%0b",
               v.name, got.op, got.v1, got.v2, got.q1, got.q2, got.des, got.imm, got.br,
               e.op, e.v1, e.v2, e.q1, e.q2, e.des, e.imm, e.br);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b0;
    inst_valid = 0; inst_op = 0; inst_rd = 0; inst_rs1 = 0; inst_rs2 = 0;
    inst_uses_rs2 = 0; inst_writes_rd = 0; inst_imm = 0; inst_is_branch = 0;
    rs_full = 0; alu_des_in = 0; memory_des_in = 0; alu_data = 0; memory_data = 0;
    commit_valid = 0; commit_tag = 0; flush = 0;
    @(posedge clk); #1;

    // Reset: instruction present but not accepted, outputs at reset values.
    v = mk("reset", ADD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    run_one(v);
    chk32("reset_stall_rs", stall_rs_cnt, 32'd0);
    chk32("reset_stall_tag", stall_tag_cnt, 32'd0);
    rst = 1'b1;

    // Vector table
    v = mk("add_x3", ADD, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.e_rdy = 1; v.e = pk(ADD, 0, 0, 0, 0, 3'd1, 0, 0); vt.push_back(v);
    v = mk("dep_query", ADD, 5'd4, 5'd3, 5'd3, 1'b1, 1'b1, 32'h0, 1'b0);
    v.e_rdy = 1; v.e = pk(ADD, 0, 0, 3'd1, 3'd1, 3'd2, 0, 0); vt.push_back(v);
    v = mk("alu_bypass", ADD, 5'd5, 5'd3, 5'd3, 1'b1, 1'b1, 32'h0, 1'b0);
    v.ad = 3'd1; v.adat = 32'h55;
    v.e_rdy = 1; v.e = pk(ADD, 32'h55, 32'h55, 0, 0, 3'd3, 0, 0); vt.push_back(v);
    v = mk("stored_and_mem", ADD, 5'd6, 5'd3, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0);
    v.md = 3'd2; v.mdat = 32'h77;
    v.e_rdy = 1; v.e = pk(ADD, 32'h55, 32'h77, 0, 0, 3'd4, 0, 0); vt.push_back(v);
    v = mk("sw_imm", SW, 5'd0, 5'd4, 5'd9, 1'b0, 1'b0, 32'h10, 1'b0);
    v.e_rdy = 1; v.e = pk(SW, 32'h77, 32'h10, 0, 0, 3'd5, 32'h10, 0); vt.push_back(v);
    v = mk("branch_q", BEQ, 5'd0, 5'd6, 5'd5, 1'b1, 1'b0, 32'h8, 1'b1);
    v.e_rdy = 1; v.e = pk(BEQ, 0, 0, 3'd4, 3'd3, 3'd6, 32'h8, 1'b1); vt.push_back(v);
    for (int i = 0; i < 3; i++) begin
      v = mk($sformatf("rs_full_%0d", i), ADD, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
      v.full = 1'b1; vt.push_back(v);
    end
    v = mk("last_tag", ADD, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.e_rdy = 1; v.e = pk(ADD, 0, 0, 0, 0, 3'd7, 0, 0); vt.push_back(v);
    v = mk("tags_full_commit1", ADD, 5'd8, 5'd3, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.cv = 1'b1; v.ct = 3'd1; vt.push_back(v);
    v = mk("reuse_tag1", ADD, 5'd8, 5'd3, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.e_rdy = 1; v.e = pk(ADD, 32'h55, 0, 0, 0, 3'd1, 0, 0); vt.push_back(v);
    v = mk("tags_full_commit5", ADD, 5'd9, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.cv = 1'b1; v.ct = 3'd5; vt.push_back(v);
    v = mk("commit_vs_rename", ADD, 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.cv = 1'b1; v.ct = 3'd2;
    v.e_rdy = 1; v.e = pk(ADD, 0, 0, 0, 0, 3'd5, 0, 0); vt.push_back(v);
    v = mk("rename_kept", ADD, 5'd9, 5'd4, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.e_rdy = 1; v.e = pk(ADD, 0, 0, 3'd5, 0, 3'd2, 0, 0); vt.push_back(v);

    foreach (vt[i]) run_one(vt[i]);

    chk32("stall_rs_cnt", stall_rs_cnt, PERF ? 32'd3 : 32'd0);
    chk32("stall_tag_cnt", stall_tag_cnt, PERF ? 32'd2 : 32'd0);

    // Flush with tags in flight; regfile keeps committed x3=0x55, x4=0x77.
    v = mk("flush", ADD, 5'd10, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.fl = 1'b1; run_one(v);
    chk32("flush_stall_rs", stall_rs_cnt, 32'd0);
    chk32("flush_stall_tag", stall_tag_cnt, 32'd0);
    v = mk("post_flush_x3", ADD, 5'd5, 5'd3, 5'd0, 1'b1, 1'b1, 32'h0, 1'b0);
    v.e_rdy = 1; v.e = pk(ADD, 32'h55, 0, 0, 0, 3'd1, 0, 0); run_one(v);
    v = mk("post_flush_x4", ADD, 5'd6, 5'd4, 5'd4, 1'b1, 1'b1, 32'h0, 1'b0);
    v.e_rdy = 1; v.e = pk(ADD, 32'h77, 32'h77, 0, 0, 3'd2, 0, 0); run_one(v);

    // Idle cycle: bubble.
    v = mk("idle", ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0, 1'b0);
    v.valid = 1'b0; v.e_rdy = 1'b1; run_one(v);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
